// File: rtl/mips_dmem_ctrl.sv
// MEM-stage data memory: byte/half/word access, valid/ready requests, 1-cycle response.
// Optional alignment check with DMEM_ALIGN_CHECK_EN.
module mips_dmem_ctrl #(
  parameter int          DATA_DEPTH = 256,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] INIT_WORD0 = 32'h00000001,
  parameter logic [31:0] INIT_WORD1 = 32'h00000002
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IDXW = $clog2(DATA_DEPTH);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t            state, stateNxt;
  logic [IDXW-1:0]   initPtr, initPtrNxt;
  logic [31:0]       initVal;

  logic [31:0]       mem [DATA_DEPTH];

  logic [ADDR_WIDTH-3:0] wordIdx;
  logic [IDXW-1:0]   memIdx;
  logic              outRange;
  logic              sizeBad;
  logic              misalign;
  logic              err;
  logic              accept;
  logic              doWrite;
  logic [3:0]        byteEn;
  logic [31:0]       laneData;
  logic [31:0]       rdWord;
  logic [7:0]        selByte;
  logic [15:0]       selHalf;
  logic [31:0]       loadData;

  always_comb begin
    stateNxt   = state;
    initPtrNxt = initPtr;
    unique case (state)
      INIT: begin
        initPtrNxt = initPtr + 1'b1;
        if (initPtr == IDXW'(DATA_DEPTH - 1))
          stateNxt = READY;
      end
      READY: stateNxt = READY;
      default: stateNxt = INIT;
    endcase
  end

  assign req_ready = (state == READY);
  assign accept    = req_valid & req_ready;

  always_comb begin
    initVal = 32'h0;
    if (initPtr == IDXW'(0))
      initVal = INIT_WORD0;
    else if (initPtr == IDXW'(1))
      initVal = INIT_WORD1;
  end

  // Bits above the array index flag an out-of-range word.
  assign wordIdx  = req_addr[ADDR_WIDTH-1:2];
  assign memIdx   = wordIdx[IDXW-1:0];
  assign outRange = |(wordIdx >> IDXW);
  assign sizeBad  = (req_size == 2'b11);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) |
                    ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err     = outRange | sizeBad | misalign;
  assign doWrite = accept & req_we & ~err;

  always_comb begin
    byteEn   = 4'b0000;
    laneData = 32'h0;
    unique case (req_size)
      2'b00: begin
        byteEn   = 4'b0001 << req_addr[1:0];
        laneData = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byteEn   = req_addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byteEn   = 4'b1111;
        laneData = req_wdata;
      end
      default: begin
        byteEn   = 4'b0000;
        laneData = 32'h0;
      end
    endcase
  end

  // Single write port shared by the INIT clear and byte-lane stores.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[initPtr] <= initVal;
    end else if (doWrite) begin
      for (int k = 0; k < 4; k++)
        if (byteEn[k])
          mem[memIdx][8*k +: 8] <= laneData[8*k +: 8];
    end
  end

  assign rdWord  = mem[memIdx];
  assign selByte = rdWord[8*req_addr[1:0] +: 8];
  assign selHalf = req_addr[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadData = 32'h0;
    unique case (req_size)
      2'b00: loadData = req_unsigned ? {24'h0, selByte}
                                     : {{24{selByte[7]}}, selByte};
      2'b01: loadData = req_unsigned ? {16'h0, selHalf}
                                     : {{16{selHalf[15]}}, selHalf};
      2'b10: loadData = rdWord;
      default: loadData = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      initPtr    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state      <= stateNxt;
      initPtr    <= initPtrNxt;
      resp_valid <= accept;
      resp_err   <= accept & err;
      resp_rdata <= (accept & ~req_we & ~err) ? loadData : 32'h0;
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed bench for mips_dmem_ctrl: default instance plus a 64-word instance
// for range checks, both driven from the same request bus.
module tb_mips_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy, rv, er;
  logic [31:0] rd;
  logic        rdy64, rv64, er64;
  logic [31:0] rd64;

  int total = 0;
  int bad = 0;

  mips_dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv), .resp_rdata(rd), .resp_err(er)
  );

  mips_dmem_ctrl #(.DATA_DEPTH(64), .ADDR_WIDTH(10)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy64),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv64), .resp_rdata(rd64), .resp_err(er64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setReq(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [9:0] a,
                        input logic [31:0] wd);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // One accepted request; returns the response seen one cycle later.
  task automatic xfer(input logic sel64, input logic we,
                      input logic [1:0] sz, input logic uns,
                      input logic [9:0] a, input logic [31:0] wd,
                      output logic v, output logic [31:0] d,
                      output logic e);
    setReq(we, sz, uns, a, wd);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    v = sel64 ? rv64 : rv;
    d = sel64 ? rd64 : rd;
    e = sel64 ? er64 : er;
  endtask

  task automatic waitInit(input string tag);
    int cnt;
    int spur;
    cnt = 0;
    spur = 0;
    while (!rdy && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rv && cnt < 256) spur++;
    end
    total++;
    if (cnt !== 256) begin
      bad++;
      $display("FAIL %s_init_len got=%0d want=256", tag, cnt);
    end
    total++;
    if (spur !== 0) begin
      bad++;
      $display("FAIL %s_init_resp got=%0d want=0", tag, spur);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0;
    setReq(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
    #17;
    total++;
    if (rdy !== 1'b0 || rv !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h e=%b want 0 0 0 0",
               rdy, rv, rd, er);
    end
  endtask

  task automatic test_init;
    logic v, e;
    logic [31:0] d;
    setReq(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
    req_valid = 1'b1;
    #3;
    rst = 1'b1;
    waitInit("t1");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++;
    if (rv !== 1'b1 || rd !== 32'h1 || er !== 1'b0) begin
      bad++;
      $display("FAIL held_lw0 got v=%b d=%h e=%b want 1 00000001 0", rv, rd, er);
    end
    xfer(0, 0, 2'b10, 0, 10'h004, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h2 || e !== 1'b0) begin
      bad++;
      $display("FAIL lw4 got v=%b d=%h e=%b want 1 00000002 0", v, d, e);
    end
    xfer(0, 0, 2'b10, 0, 10'h008, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL lw8 got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    @(posedge clk);
    #1;
    total++;
    if (rv !== 1'b0) begin
      bad++;
      $display("FAIL resp_pulse got v=%b want 0", rv);
    end
  endtask

  task automatic test_back_to_back;
    logic v, e;
    logic [31:0] d;
    logic [9:0]  ad [4] = '{10'h011, 10'h013, 10'h012, 10'h010};
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        us [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex [4] = '{32'h000000C3, 32'hFFFFFFA1,
                            32'h0000A1B2, 32'hFFFFC3D4};
    xfer(0, 1, 2'b10, 0, 10'h010, 32'hA1B2C3D4, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL sw10 got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    setReq(1'b0, sz[0], us[0], ad[0], 32'h0);
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rv !== 1'b1 || rd !== ex[i] || er !== 1'b0 || rdy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d got v=%b d=%h e=%b rdy=%b want 1 %h 0 1",
                 i, rv, rd, er, rdy, ex[i]);
      end
      if (i < 3) setReq(1'b0, sz[i+1], us[i+1], ad[i+1], 32'h0);
      else req_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if (rv !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got v=%b want 0", rv);
    end
  endtask

  task automatic test_lanes;
    logic v, e;
    logic [31:0] d;
    xfer(0, 1, 2'b00, 0, 10'h012, 32'h0000007F, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL sb12 got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    xfer(0, 1, 2'b01, 0, 10'h010, 32'h00001234, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL sh10 got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    xfer(0, 0, 2'b10, 0, 10'h010, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'hA17F1234 || e !== 1'b0) begin
      bad++;
      $display("FAIL lw_merge got v=%b d=%h e=%b want 1 a17f1234 0", v, d, e);
    end
  endtask

  task automatic test_errors;
    logic v, e;
    logic [31:0] d;
    xfer(1, 1, 2'b10, 0, 10'h100, 32'hDEADBEEF, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL oor_sw got v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    xfer(1, 0, 2'b10, 0, 10'h100, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL oor_lw got v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    xfer(1, 0, 2'b10, 0, 10'h0FC, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL last_lw got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    xfer(0, 0, 2'b11, 0, 10'h020, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL size11 got v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
  endtask

  task automatic test_align;
    logic v, e;
    logic [31:0] d;
    xfer(0, 1, 2'b10, 0, 10'h010, 32'hA1B2C3D4, v, d, e);
    xfer(0, 0, 2'b01, 1, 10'h011, 0, v, d, e);
`ifdef DMEM_ALIGN_CHECK_EN
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL mis_lhu got v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    xfer(0, 1, 2'b10, 0, 10'h012, 32'hFFFFFFFF, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL mis_sw got v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    xfer(0, 0, 2'b10, 0, 10'h010, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'hA1B2C3D4 || e !== 1'b0) begin
      bad++;
      $display("FAIL mis_keep got v=%b d=%h e=%b want 1 a1b2c3d4 0", v, d, e);
    end
`else
    total++;
    if (v !== 1'b1 || d !== 32'h0000C3D4 || e !== 1'b0) begin
      bad++;
      $display("FAIL lhu11 got v=%b d=%h e=%b want 1 0000c3d4 0", v, d, e);
    end
    xfer(0, 0, 2'b10, 0, 10'h012, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'hA1B2C3D4 || e !== 1'b0) begin
      bad++;
      $display("FAIL lw12 got v=%b d=%h e=%b want 1 a1b2c3d4 0", v, d, e);
    end
`endif
  endtask

  task automatic test_reset_midstream;
    logic v, e;
    logic [31:0] d;
    xfer(0, 1, 2'b10, 0, 10'h010, 32'h00000055, v, d, e);
    setReq(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rv !== 1'b1 || rd !== 32'h55) begin
      bad++;
      $display("FAIL pre_rst got v=%b d=%h want 1 00000055", rv, rd);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    total++;
    if (rv !== 1'b0 || rdy !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got v=%b rdy=%b d=%h e=%b want 0 0 0 0",
               rv, rdy, rd, er);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    waitInit("t6");
    xfer(0, 0, 2'b10, 0, 10'h010, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++;
      $display("FAIL reinit_lw10 got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    xfer(0, 0, 2'b10, 0, 10'h000, 0, v, d, e);
    total++;
    if (v !== 1'b1 || d !== 32'h1 || e !== 1'b0) begin
      bad++;
      $display("FAIL reinit_lw0 got v=%b d=%h e=%b want 1 00000001 0", v, d, e);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_back_to_back;
    test_lanes;
    test_errors;
    test_align;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
